// File: rtl/falling_edge_pkg.sv
// Shared types and helpers for the falling-edge event bus transmitter.
//   feg_state_t : FSM state encoding
//   onehot_dec  : index -> one-hot vector, zero when idx >= width
//   max2        : larger of two ints, used for counter sizing
package falling_edge_pkg;

  typedef enum logic [1:0] {
    FEG_IDLE = 2'd0,
    FEG_HIGH = 2'd1,
    FEG_LOW  = 2'd2
  } feg_state_t;

  localparam int FEG_MAX_WIDTH = 256;

  function automatic logic [FEG_MAX_WIDTH-1:0] onehot_dec(input logic [7:0] idx, input int width);
    logic [FEG_MAX_WIDTH-1:0] v;
    v = '0;
    if (int'(idx) < width) v[idx] = 1'b1;
    return v;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/falling_edge_req_fifo.sv
// Request queue for the falling-edge generator.
//   clk_i, reset_i : clock, synchronous active-high reset (flushes pointers/count)
//   push_i/data_i  : write request; dropped when full unless a pop happens too
//   pop_i/data_o   : read request; data_o shows the head entry combinationally
//   full_o/empty_o/count_o : occupancy
module falling_edge_req_fifo
  import falling_edge_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // At full, a simultaneous pop frees the head slot, which is the one written.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/falling_edge_generator.sv
// Transmit side of the falling-edge event bus. Each accepted in-range index
// produces one HOLD_CYCLES-wide pulse on exactly one bus bit, followed by at
// least GAP_CYCLES+1 all-zero cycles before the next pulse.
//   clk_i, reset_i : clock, synchronous active-high reset
//   req_valid_i/req_ready_o/req_idx_i : request handshake (ready = queue not full)
//   out_o  : event bus, one-hot or zero
//   busy_o : FSM active or requests pending
//   done_o : one-cycle pulse in the cycle the bus returns to zero
//   err_o  : one-cycle pulse after accepting an index >= WIDTH
//
// state    | meaning
// FEG_IDLE | bus zero; pops the next request if one is queued
// FEG_HIGH | selected bit high, counting down the hold time
// FEG_LOW  | bus zero, counting down the inter-pulse gap
module falling_edge_generator
  import falling_edge_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int IDX_W       = $clog2(WIDTH),
  parameter int HOLD_CYCLES = 1,
  parameter int GAP_CYCLES  = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [IDX_W-1:0] req_idx_i,
  output logic [WIDTH-1:0] out_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int CNT_W = $clog2(max2(HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [IDX_W:0]   WIDTH_L   = (IDX_W+1)'(WIDTH);

  if (HOLD_CYCLES < 1) begin : g_chk_hold
    $error("falling_edge_generator: HOLD_CYCLES must be >= 1");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_chk_depth
    $error("falling_edge_generator: FIFO_DEPTH must be a power of 2, >= 2");
  end
  if ((WIDTH < 2) || (WIDTH > FEG_MAX_WIDTH)) begin : g_chk_width
    $error("falling_edge_generator: WIDTH must be in 2..256");
  end

  feg_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             accept, in_range, push, pop;
  logic             fifo_full, fifo_empty;
  logic [IDX_W-1:0] fifo_rd_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign req_ready_o = !fifo_full;
  assign accept      = req_valid_i && req_ready_o;
  assign in_range    = ({1'b0, req_idx_i} < WIDTH_L);
  assign push        = accept && in_range;
  assign err_d       = accept && !in_range;

  falling_edge_req_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (IDX_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push),
    .data_i  (req_idx_i),
    .pop_i   (pop),
    .data_o  (fifo_rd_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      FEG_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          out_d   = WIDTH'(onehot_dec(8'(fifo_rd_data), WIDTH));
          cnt_d   = HOLD_LOAD;
          state_d = FEG_HIGH;
        end
      end
      FEG_HIGH: begin
        if (cnt_q == '0) begin
          out_d  = '0;
          done_d = 1'b1;
          if (GAP_CYCLES == 0) begin
            state_d = FEG_IDLE;
          end else begin
            state_d = FEG_LOW;
            cnt_d   = GAP_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FEG_LOW: begin
        if (cnt_q == '0) state_d = FEG_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = FEG_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= FEG_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign out_o  = out_q;
  assign done_o = done_q;
  assign err_o  = err_q;
  assign busy_o = (state_q != FEG_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_falling_edge_generator.sv
module tb_falling_edge_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // a: defaults, b: HOLD=3 GAP=2, c: GAP=0, d: WIDTH=20
  logic        rst_a, vld_a, rdy_a, busy_a, done_a, err_a;
  logic [4:0]  idx_a;
  logic [31:0] out_a;
  logic        rst_b, vld_b, rdy_b, busy_b, done_b, err_b;
  logic [4:0]  idx_b;
  logic [31:0] out_b;
  logic        rst_c, vld_c, rdy_c, busy_c, done_c, err_c;
  logic [4:0]  idx_c;
  logic [31:0] out_c;
  logic        rst_d, vld_d, rdy_d, busy_d, done_d, err_d;
  logic [4:0]  idx_d;
  logic [19:0] out_d;

  falling_edge_generator u_dut_a (
    .clk_i(clk), .reset_i(rst_a), .req_valid_i(vld_a), .req_ready_o(rdy_a),
    .req_idx_i(idx_a), .out_o(out_a), .busy_o(busy_a), .done_o(done_a), .err_o(err_a));

  falling_edge_generator #(.HOLD_CYCLES(3), .GAP_CYCLES(2)) u_dut_b (
    .clk_i(clk), .reset_i(rst_b), .req_valid_i(vld_b), .req_ready_o(rdy_b),
    .req_idx_i(idx_b), .out_o(out_b), .busy_o(busy_b), .done_o(done_b), .err_o(err_b));

  falling_edge_generator #(.GAP_CYCLES(0)) u_dut_c (
    .clk_i(clk), .reset_i(rst_c), .req_valid_i(vld_c), .req_ready_o(rdy_c),
    .req_idx_i(idx_c), .out_o(out_c), .busy_o(busy_c), .done_o(done_c), .err_o(err_c));

  falling_edge_generator #(.WIDTH(20)) u_dut_d (
    .clk_i(clk), .reset_i(rst_d), .req_valid_i(vld_d), .req_ready_o(rdy_d),
    .req_idx_i(idx_d), .out_o(out_d), .busy_o(busy_d), .done_o(done_d), .err_o(err_d));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int lsb(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Bus monitor: detector model plus pulse accounting
  logic        mon_en = 1'b0;
  logic        rst_seen [4];
  logic [31:0] prev_out [4];
  int          acc_cnt [4] = '{0, 0, 0, 0};
  int          base_acc [4] = '{0, 0, 0, 0};
  int          done_cnt [4] = '{0, 0, 0, 0};
  int          base_done [4] = '{0, 0, 0, 0};
  int          det_a [$];
  int          det_b [$];

  always @(posedge clk) begin
    rst_seen[0] <= rst_a;
    rst_seen[1] <= rst_b;
    rst_seen[2] <= rst_c;
    rst_seen[3] <= rst_d;
    if (rst_a) begin base_acc[0] <= acc_cnt[0]; base_done[0] <= done_cnt[0]; end
    else if (vld_a && rdy_a) acc_cnt[0] <= acc_cnt[0] + 1;
    if (rst_b) begin base_acc[1] <= acc_cnt[1]; base_done[1] <= done_cnt[1]; end
    else if (vld_b && rdy_b) acc_cnt[1] <= acc_cnt[1] + 1;
    if (rst_c) begin base_acc[2] <= acc_cnt[2]; base_done[2] <= done_cnt[2]; end
    else if (vld_c && rdy_c) acc_cnt[2] <= acc_cnt[2] + 1;
    if (rst_d) begin base_acc[3] <= acc_cnt[3]; base_done[3] <= done_cnt[3]; end
    else if (vld_d && rdy_d && (idx_d < 5'd20)) acc_cnt[3] <= acc_cnt[3] + 1;
  end

  task automatic mon(input int d, input logic [31:0] o, input logic dn, output int ev);
    logic fell;
    fell = (prev_out[d] != '0) && (o == '0) && !rst_seen[d];
    ev = fell ? lsb(prev_out[d]) : -1;
    chk($sformatf("d%0d_onehot0", d), {31'b0, $onehot0(o)}, 32'd1);
    chk($sformatf("d%0d_done_on_fall", d), {31'b0, dn}, {31'b0, fell});
  endtask

  always @(negedge clk) begin
    int ev;
    if (mon_en) begin
      mon(0, out_a, done_a, ev);
      if (ev >= 0) det_a.push_back(ev);
      mon(1, out_b, done_b, ev);
      if (ev >= 0) det_b.push_back(ev);
      mon(2, out_c, done_c, ev);
      mon(3, {12'b0, out_d}, done_d, ev);
      done_cnt[0] <= done_cnt[0] + int'(done_a);
      done_cnt[1] <= done_cnt[1] + int'(done_b);
      done_cnt[2] <= done_cnt[2] + int'(done_c);
      done_cnt[3] <= done_cnt[3] + int'(done_d);
    end
    prev_out[0] <= out_a;
    prev_out[1] <= out_b;
    prev_out[2] <= out_c;
    prev_out[3] <= {12'b0, out_d};
  end

  initial begin
    logic [31:0] exp2 [15];
    int          seq3 [8];
    int          acc, edges, guard;
    logic        rdy_before, any_hi;

    exp2 = '{32'h1, 32'h1, 32'h1, 32'h0, 32'h0, 32'h0,
             32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, 32'h0,
             32'h80, 32'h80, 32'h80};
    seq3 = '{3, 14, 27, 8, 19, 30, 1, 22};

    rst_a = 1; rst_b = 1; rst_c = 1; rst_d = 1;
    vld_a = 0; vld_b = 0; vld_c = 0; vld_d = 0;
    idx_a = 0; idx_b = 0; idx_c = 0; idx_d = 0;
    step(2);
    chk("rst_out_a", out_a, 0);
    chk("rst_done_a", {31'b0, done_a}, 0);
    chk("rst_err_a", {31'b0, err_a}, 0);
    chk("rst_busy_a", {31'b0, busy_a}, 0);
    chk("rst_ready_a", {31'b0, rdy_a}, 1);
    chk("rst_out_b", out_b, 0);
    chk("rst_out_d", {12'b0, out_d}, 0);
    rst_a = 0; rst_b = 0; rst_c = 0; rst_d = 0;
    mon_en = 1;
    step(1);

    // single request, default timing
    vld_a = 1; idx_a = 5;
    step(1);
    vld_a = 0;
    chk("t1_out_k", out_a, 0);
    chk("t1_busy_k", {31'b0, busy_a}, 1);
    step(1);
    chk("t1_out_k1", out_a, 32'h20);
    chk("t1_done_k1", {31'b0, done_a}, 0);
    step(1);
    chk("t1_out_k2", out_a, 0);
    chk("t1_done_k2", {31'b0, done_a}, 1);
    chk("t1_busy_k2", {31'b0, busy_a}, 1);
    step(1);
    chk("t1_done_k3", {31'b0, done_a}, 0);
    step(1);
    chk("t1_busy_k4", {31'b0, busy_a}, 0);
    chk("t1_det", det_a.size() == 1 ? det_a[0] : -1, 5);

    // out-of-range and boundary indices on a 20-bit bus
    vld_d = 1; idx_d = 25;
    step(1);
    vld_d = 0;
    chk("t4_err_25", {31'b0, err_d}, 1);
    chk("t4_out_25", {12'b0, out_d}, 0);
    chk("t4_busy_25", {31'b0, busy_d}, 0);
    step(1);
    chk("t4_err_clear", {31'b0, err_d}, 0);
    chk("t4_out_after", {12'b0, out_d}, 0);
    chk("t4_done_after", {31'b0, done_d}, 0);
    vld_d = 1; idx_d = 20;
    step(1);
    vld_d = 0;
    chk("t4_err_20", {31'b0, err_d}, 1);
    step(1);
    vld_d = 1; idx_d = 19;
    step(1);
    vld_d = 0;
    chk("t4_err_19", {31'b0, err_d}, 0);
    step(1);
    chk("t4_out_19", {12'b0, out_d}, 32'h8_0000);
    step(1);
    chk("t4_done_19", {31'b0, done_d}, 1);

    // HOLD=3 GAP=2 back-to-back 0, 31, 7
    vld_b = 1; idx_b = 0;
    step(1);
    idx_b = 31;
    step(1);
    chk("t2_out_c2", out_b, exp2[0]);
    idx_b = 7;
    step(1);
    vld_b = 0;
    chk("t2_out_c3", out_b, exp2[1]);
    for (int i = 2; i < 15; i++) begin
      step(1);
      chk($sformatf("t2_out_c%0d", i + 2), out_b, exp2[i]);
      chk($sformatf("t2_done_c%0d", i + 2), {31'b0, done_b}, (i == 3 || i == 9) ? 32'd1 : 32'd0);
    end
    step(1);
    chk("t2_out_c17", out_b, 0);
    chk("t2_done_c17", {31'b0, done_b}, 1);
    step(3);
    chk("t2_det_n", det_b.size(), 3);
    chk("t2_det_0", det_b.size() > 0 ? det_b[0] : -1, 0);
    chk("t2_det_1", det_b.size() > 1 ? det_b[1] : -1, 31);
    chk("t2_det_2", det_b.size() > 2 ? det_b[2] : -1, 7);
    det_b.delete();

    // reset while HIGH with three requests queued
    vld_b = 1; idx_b = 1;
    step(1);
    idx_b = 2;
    step(1);
    idx_b = 3;
    step(1);
    idx_b = 4;
    step(1);
    vld_b = 0;
    chk("t5_out_pre", out_b, 32'h2);
    chk("t5_busy_pre", {31'b0, busy_b}, 1);
    rst_b = 1;
    step(1);
    rst_b = 0;
    chk("t5_out_rst", out_b, 0);
    chk("t5_done_rst", {31'b0, done_b}, 0);
    chk("t5_busy_rst", {31'b0, busy_b}, 0);
    chk("t5_ready_rst", {31'b0, rdy_b}, 1);
    any_hi = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      any_hi = any_hi | (|out_b) | busy_b;
    end
    chk("t5_quiet", {31'b0, any_hi}, 0);
    vld_b = 1; idx_b = 9;
    step(1);
    vld_b = 0;
    step(1);
    chk("t5_new_out1", out_b, 32'h200);
    step(2);
    chk("t5_new_out3", out_b, 32'h200);
    step(1);
    chk("t5_new_out4", out_b, 0);
    chk("t5_new_done", {31'b0, done_b}, 1);
    step(1);
    chk("t5_det_n", det_b.size(), 1);
    chk("t5_det_0", det_b.size() > 0 ? det_b[0] : -1, 9);

    // GAP=0: exactly one zero cycle between pulses
    vld_c = 1; idx_c = 2;
    step(1);
    idx_c = 3;
    step(1);
    vld_c = 0;
    chk("t6_out_c2", out_c, 32'h4);
    step(1);
    chk("t6_out_c3", out_c, 0);
    chk("t6_done_c3", {31'b0, done_c}, 1);
    step(1);
    chk("t6_out_c4", out_c, 32'h8);
    step(1);
    chk("t6_out_c5", out_c, 0);
    chk("t6_done_c5", {31'b0, done_c}, 1);

    // valid held high; pops at edges 2,5,8,11 so accepts land on edges 1-6, 9, 12
    det_a.delete();
    acc = 0; edges = 0;
    vld_a = 1; idx_a = seq3[0];
    while (acc < 8 && edges < 40) begin
      rdy_before = rdy_a;
      step(1);
      edges++;
      if (rdy_before) begin
        acc++;
        if (acc == 5) chk("t3_ready_after_5", {31'b0, rdy_a}, 1);
        if (acc == 6) chk("t3_ready_after_6", {31'b0, rdy_a}, 0);
        if (acc < 8) idx_a = seq3[acc];
      end
    end
    vld_a = 0;
    chk("t3_accepts", acc, 8);
    chk("t3_edges", edges, 12);
    guard = 0;
    while (det_a.size() < 8 && guard < 60) begin
      step(1);
      guard++;
    end
    chk("t3_det_n", det_a.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t3_det_%0d", i), det_a.size() > i ? det_a[i] : -1, seq3[i]);

    step(6);
    chk("acct_a", (acc_cnt[0] - base_acc[0]) - (done_cnt[0] - base_done[0]), 0);
    chk("acct_b", (acc_cnt[1] - base_acc[1]) - (done_cnt[1] - base_done[1]), 0);
    chk("acct_c", (acc_cnt[2] - base_acc[2]) - (done_cnt[2] - base_done[2]), 0);
    chk("acct_d", (acc_cnt[3] - base_acc[3]) - (done_cnt[3] - base_done[3]), 0);
    chk("final_busy_a", {31'b0, busy_a}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
